// File: rtl/keccak_padder_if.sv
// Message-word stream and padded-block handshake between the host port,
// the padder and f_permutation.
interface keccak_padder_if;
  logic [63:0]   in;
  logic          in_valid;
  logic          is_last;
  logic [2:0]    byte_num;
  logic          ack;
  logic [1151:0] out;
  logic          out_ready;
  logic          out_last;
  logic          f_ack;

  // master: host plus permutation side; slave: the padder itself
  modport master (
    output in, in_valid, is_last, byte_num, f_ack,
    input  ack, out, out_ready, out_last
  );

  modport slave (
    input  in, in_valid, is_last, byte_num, f_ack,
    output ack, out, out_ready, out_last
  );
endinterface

// File: rtl/keccak_padder.sv
// SHA-3 absorb front end: packs 64-bit message words into a rate-sized block,
// applies 0x06 ... 0x80 padding and hands blocks to f_permutation.
module keccak_padder (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  keccak_padder_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ABSORB = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  logic [1:0] state_reg;
  logic [1:0] mode_reg;
  logic [4:0] cnt_reg;
  logic       out_last_reg;
  logic [4:0] last_slot;
  logic       take;
  logic       release_blk;
  logic [5:0] pad_shift;
  logic [63:0] keep_mask;
  logic [63:0] last_word;
  logic [63:0] store_word;

  // Index of the final word slot of the block for the latched rate
  always_comb begin
    last_slot = 5'd8;
    case (mode_reg)
      2'b00:   last_slot = 5'd17;
      2'b01:   last_slot = 5'd16;
      2'b10:   last_slot = 5'd12;
      default: last_slot = 5'd8;
    endcase
  end

  assign take        = (state_reg == ABSORB) && bus.in_valid;
  assign release_blk = (state_reg == FULL) && bus.f_ack;

  // Final word keeps byte_num data bytes and carries the 0x06 suffix right after them
  assign pad_shift  = {bus.byte_num, 3'b000};
  assign keep_mask  = (64'd1 << pad_shift) - 64'd1;
  assign last_word  = (bus.in & keep_mask) | (64'h06 << pad_shift);
  assign store_word = bus.is_last ? last_word : bus.in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'b00;
      cnt_reg      <= 5'd0;
      out_last_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg  <= mode;
            cnt_reg   <= 5'd0;
            state_reg <= ABSORB;
          end
        end
        ABSORB: begin
          if (bus.in_valid) begin
            if (bus.is_last) begin
              out_last_reg <= 1'b1;
              state_reg    <= FULL;
            end else if (cnt_reg == last_slot) begin
              out_last_reg <= 1'b0;
              state_reg    <= FULL;
            end else begin
              cnt_reg <= cnt_reg + 5'd1;
            end
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            cnt_reg      <= 5'd0;
            out_last_reg <= 1'b0;
            state_reg    <= out_last_reg ? IDLE : ABSORB;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack       = (state_reg == ABSORB);
  assign bus.out_ready = (state_reg == FULL);
  assign bus.out_last  = out_last_reg;

  // One register per word slot; slots beyond the current rate are never written
  generate
    for (genvar gi = 0; gi < 18; gi++) begin : g_slot
      logic [63:0] word_reg;
      logic        hit;
      logic        tail;

      assign hit  = take && (cnt_reg == 5'(gi));
      assign tail = take && bus.is_last && (last_slot == 5'(gi));

      always_ff @(posedge clk) begin
        if (rst || release_blk) begin
          word_reg <= 64'd0;
        end else if (hit && tail) begin
          word_reg <= store_word | {8'h80, 56'd0};
        end else if (hit) begin
          word_reg <= store_word;
        end else if (tail) begin
          word_reg <= word_reg | {8'h80, 56'd0};
        end
      end

      assign bus.out[64*gi +: 64] = word_reg;
    end
  endgenerate

endmodule
